uart_tx_fifo: RTL

- UART transmit core that sits inside the Tiny Tapeout user project, directly behind the pin-level wrapper.
- The wrapper feeds it bytes from ui_in and drives one uo_out bit from its serial line.
- It buffers bytes in a small FIFO and serialises them as 8N1 frames at a fixed baud rate derived from the system clock.
- Back-to-back frames are sent with no idle gap.

---
 rtl/uart_tx_pkg.sv | 20 ++
 rtl/uart_tx_fifo_sync_fifo.sv | 54 +++++
 rtl/uart_tx_fifo.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/uart_tx_pkg.sv
// Shared types and line constants for the UART transmit path.
// Build option: UART_TX_PARITY_EN adds an even-parity bit after the data bits.
package uart_tx_pkg;

    localparam int   DATA_BITS  = 8;
    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;
    localparam logic IDLE_LEVEL = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        ST_PARITY = 3'd4,
`endif
        ST_STOP   = 3'd3
    } state_e;

endpackage

// File: rtl/uart_tx_fifo_sync_fifo.sv
// Single-clock FIFO with binary pointers carrying an extra wrap bit.
// The read head is combinational so a pop can load it on the same edge.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           wdata_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           rdata_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int CW = $clog2(DEPTH + 1);

    generate
        if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_chk
            $error("sync_fifo: DEPTH must be a power of two and at least 2");
        end
    endgenerate

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wptr_q, rptr_q;
    logic             do_push, do_pop;

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign count_o = CW'(wptr_q - rptr_q);
    assign rdata_o = mem_q[rptr_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata_i;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + PW'(1);
            if (do_pop)  rptr_q <= rptr_q + PW'(1);
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter; frames are sent back-to-back with no idle gap.
// Build option: UART_TX_PARITY_EN inserts an even-parity bit (11-bit frames).
module uart_tx_fifo
    import uart_tx_pkg::*;
#(
    parameter int CLK_HZ     = 50_000_000,
    parameter int BAUD       = 115_200,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            in_valid,
    input  logic [7:0]                      in_data,
    output logic                            in_ready,
    output logic                            tx,
    output logic                            busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count
);

    localparam int DIV   = CLK_HZ / BAUD;
    localparam int CNT_W = (DIV < 2) ? 1 : $clog2(DIV);
    localparam int BIT_W = $clog2(DATA_BITS);

    generate
        if (DIV < 2) begin : g_div_chk
            $error("uart_tx_fifo: CLK_HZ / BAUD must be at least 2");
        end
    endgenerate

    logic                 fifo_full, fifo_empty, fifo_pop, fifo_push;
    logic [7:0]           fifo_head;

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [BIT_W-1:0]     bit_q, bit_d;
    logic [7:0]           shift_q, shift_d;
    logic                 tx_q, tx_d;
    logic                 baud_end;
`ifdef UART_TX_PARITY_EN
    logic                 par_q, par_d;
`endif

    assign in_ready  = !fifo_full;
    assign fifo_push = in_valid && in_ready;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (fifo_push),
        .wdata_i (in_data),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign baud_end = (cnt_q == CNT_W'(DIV - 1));

    // tx_d always carries the level of the state being entered, so tx is a pure register.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        tx_d     = tx_q;
        fifo_pop = 1'b0;

        if (state_q != ST_IDLE) cnt_d = baud_end ? '0 : cnt_q + CNT_W'(1);

        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_d  = fifo_head;
                    cnt_d    = '0;
                    state_d  = ST_START;
                    tx_d     = START_BIT;
                end
            end
            ST_START: begin
                if (baud_end) begin
                    bit_d   = '0;
                    state_d = ST_DATA;
                    tx_d    = shift_q[0];
                end
            end
            ST_DATA: begin
                if (baud_end) begin
                    if (bit_q == BIT_W'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
                        state_d = ST_PARITY;
                        tx_d    = par_q;
`else
                        state_d = ST_STOP;
                        tx_d    = STOP_BIT;
`endif
                    end else begin
                        bit_d   = bit_q + BIT_W'(1);
                        shift_d = shift_q >> 1;
                        tx_d    = shift_q[1];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (baud_end) begin
                    state_d = ST_STOP;
                    tx_d    = STOP_BIT;
                end
            end
`endif
            ST_STOP: begin
                if (baud_end) begin
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        shift_d  = fifo_head;
                        state_d  = ST_START;
                        tx_d     = START_BIT;
                    end else begin
                        state_d  = ST_IDLE;
                        tx_d     = IDLE_LEVEL;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                tx_d    = IDLE_LEVEL;
            end
        endcase
    end

`ifdef UART_TX_PARITY_EN
    // Even parity is taken from the whole byte at load time.
    assign par_d = fifo_pop ? ^fifo_head : par_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= IDLE_LEVEL;
`ifdef UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
`ifdef UART_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    assign tx   = tx_q;
    assign busy = (state_q != ST_IDLE) || (fifo_count != '0);

endmodule
